gio_bitserial_ctrl: RTL and testbench

Sequencer and shift-accumulator for the global IO datapath. It runs one bit-serial MAC operation over `IN_BITS` input bit-planes, MSB first. For each plane it drives the combine mode of the global IO adder and the index of the plane being broadcast. It accepts one combined partial sum per plane and folds it into a shift-accumulated result, which it presents on a valid/ready output. It sits between the global IO adder and the macro output register.

---
 rtl/dcim_pkg.sv | 14 +
 rtl/shift_acc.sv | 44 ++++
 rtl/gio_bitserial_ctrl.sv | 114 +++++++++++
 tb/tb_gio_bitserial_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcim_pkg.sv
// Shared definitions for the DCIM datapath: default widths used by global IO
// and the local MACs, plus the bit-serial sequencer state encoding.
package dcim_pkg;

  localparam int PSUM_WIDTH = 27;
  localparam int IN_BITS    = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/shift_acc.sv
// Shift-accumulator: sign-extends each incoming partial sum and folds it into
// acc as (acc << 1) +/- ext, modulo 2^ACC_WIDTH.
module shift_acc #(
  parameter int DIN_WIDTH = 27,
  parameter int ACC_WIDTH = 35
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 en,
  input  logic                 neg,
  input  logic [DIN_WIDTH-1:0] din,
  output logic [ACC_WIDTH-1:0] acc
);

  logic [ACC_WIDTH-1:0] acc_q;
  logic [ACC_WIDTH-1:0] acc_d;
  logic [ACC_WIDTH-1:0] ext;
  logic [ACC_WIDTH-1:0] shifted;

  assign ext     = {{(ACC_WIDTH - DIN_WIDTH){din[DIN_WIDTH-1]}}, din};
  assign shifted = {acc_q[ACC_WIDTH-2:0], 1'b0};

  // Clear has priority so a new operation never inherits a stale sum.
  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = neg ? (shifted - ext) : (shifted + ext);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/gio_bitserial_ctrl.sv
// Bit-serial MAC sequencer: walks input bit-planes MSB first, steers the global
// IO adder, and shift-accumulates one partial sum per plane into the result.
module gio_bitserial_ctrl
  import dcim_pkg::*;
#(
  parameter int PSUM_WIDTH = dcim_pkg::PSUM_WIDTH,
  parameter int IN_BITS    = dcim_pkg::IN_BITS,
  parameter int ACC_WIDTH  = 35,
  localparam int IDX_W     = $clog2(IN_BITS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  cfg_signed,
  input  logic                  cfg_sub,
  output logic                  start_ready,
  output logic                  busy,
  output logic [IDX_W-1:0]      bit_idx,
  output logic                  gio_sub,
  input  logic [PSUM_WIDTH-1:0] psum_in,
  input  logic                  psum_valid,
  output logic                  psum_ready,
  output logic [ACC_WIDTH-1:0]  out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IN_BITS - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic             signed_q, signed_d;
  logic             sub_q, sub_d;
  logic             acc_clr;
  logic             acc_en;
  logic             acc_neg;
  logic [ACC_WIDTH-1:0] acc;

  // The MSB plane carries negative weight only for signed operands.
  assign acc_neg = signed_q && (bit_idx_q == LAST_IDX);

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    signed_d  = signed_q;
    sub_d     = sub_q;
    acc_clr   = 1'b0;
    acc_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_RUN;
          bit_idx_d = LAST_IDX;
          signed_d  = cfg_signed;
          sub_d     = cfg_sub;
          acc_clr   = 1'b1;
        end
      end
      ST_RUN: begin
        if (psum_valid) begin
          acc_en = 1'b1;
          if (bit_idx_q == '0) begin
            state_d = ST_DONE;
          end else begin
            bit_idx_d = bit_idx_q - IDX_W'(1);
          end
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bit_idx_q <= '0;
      signed_q  <= 1'b0;
      sub_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      signed_q  <= signed_d;
      sub_q     <= sub_d;
    end
  end

  shift_acc #(
    .DIN_WIDTH (PSUM_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_shift_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (acc_clr),
    .en    (acc_en),
    .neg   (acc_neg),
    .din   (psum_in),
    .acc   (acc)
  );

  // Outputs are pure decodes of registered state, so they change only on edges.
  assign start_ready = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign psum_ready  = (state_q == ST_RUN);
  assign out_valid   = (state_q == ST_DONE);
  assign gio_sub     = sub_q && (state_q != ST_IDLE);
  assign bit_idx     = bit_idx_q;
  assign out_data    = acc;

endmodule

// File: tb/tb_gio_bitserial_ctrl.sv
// Randomized bench for gio_bitserial_ctrl; expected results come from a
// weighted-sum model of the bit-plane MAC computed with plain integer arithmetic.
module tb_gio_bitserial_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        cfg_signed;
  logic        cfg_sub;
  logic        start_ready;
  logic        busy;
  logic [2:0]  bit_idx;
  logic        gio_sub;
  logic [26:0] psum_in;
  logic        psum_valid;
  logic        psum_ready;
  logic [34:0] out_data;
  logic        out_valid;
  logic        out_ready;

  int checks = 0;
  int errors = 0;

  logic signed [26:0] plan [8];

  always #5 clk = ~clk;

  gio_bitserial_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .cfg_signed  (cfg_signed),
    .cfg_sub     (cfg_sub),
    .start_ready (start_ready),
    .busy        (busy),
    .bit_idx     (bit_idx),
    .gio_sub     (gio_sub),
    .psum_in     (psum_in),
    .psum_valid  (psum_valid),
    .psum_ready  (psum_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  // Result = sum of plane_value * 2^plane, with the MSB plane negated when signed.
  function automatic logic [34:0] model_result(input bit sgn);
    longint s;
    longint v;
    s = 0;
    for (int i = 0; i < 8; i++) begin
      v = plan[i];
      if (i == 7 && sgn) s = s - v * (longint'(1) << i);
      else               s = s + v * (longint'(1) << i);
    end
    return s[34:0];
  endfunction

  // Runs one operation from IDLE until out_valid; called and returns at a negedge.
  task automatic run_op(input bit sgn, input bit sub, input int stall_idx, input int stall_len,
                        input int rnd_stall_pct, input bit poke_start,
                        output logic [34:0] data, output int lat, output int seq_bad,
                        output bit timed_out);
    int cur;
    int stalled;
    bit v;
    cur = 7; stalled = 0; seq_bad = 0; lat = 0; timed_out = 0;
    start = 1'b1; cfg_signed = sgn; cfg_sub = sub;
    @(posedge clk); lat = 1;
    @(negedge clk);
    start = 1'b0; cfg_signed = ~sgn; cfg_sub = ~sub;
    while (out_valid !== 1'b1) begin
      if (lat > 100) begin
        timed_out = 1'b1;
        break;
      end
      if (psum_ready !== 1'b1 || start_ready !== 1'b0 || busy !== 1'b1 ||
          bit_idx !== 3'(cur) || gio_sub !== sub)
        seq_bad++;
      v = 1'b1;
      if (cur == stall_idx && stalled < stall_len) begin
        v = 1'b0;
        stalled++;
      end else if (rnd_stall_pct > 0 && $urandom_range(99) < rnd_stall_pct) begin
        v = 1'b0;
      end
      psum_valid = v;
      psum_in    = v ? plan[cur] : 27'($urandom);
      start      = poke_start ? 1'($urandom) : 1'b0;
      cfg_signed = 1'($urandom);
      cfg_sub    = 1'($urandom);
      @(posedge clk); lat++;
      if (v) cur--;
      @(negedge clk);
    end
    psum_valid = 1'b0;
    start      = 1'b0;
    data       = out_data;
  endtask

  // Holds backpressure for 'hold' cycles, then accepts; returns at a negedge in IDLE.
  task automatic finish_op(input int hold, input bit poke_start, input bit sub,
                           output int unstable, output int post_bad);
    logic [34:0] d0;
    d0 = out_data;
    unstable = 0;
    repeat (hold) begin
      out_ready = 1'b0;
      start = poke_start ? 1'($urandom) : 1'b0;
      @(posedge clk);
      @(negedge clk);
      if (out_valid !== 1'b1 || out_data !== d0 || start_ready !== 1'b0 || gio_sub !== sub)
        unstable++;
    end
    out_ready = 1'b1;
    start = poke_start;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    start = 1'b0;
    post_bad = (start_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 ||
                psum_ready !== 1'b0 || gio_sub !== 1'b0) ? 1 : 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; cfg_signed = 0; cfg_sub = 0;
    psum_in = '0; psum_valid = 0; out_ready = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (start_ready !== 1'b1 || busy !== 1'b0 || psum_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got sr=%b busy=%b pr=%b ov=%b, need 1 0 0 0",
               start_ready, busy, psum_ready, out_valid);
    end
    checks++;
    if (bit_idx !== 3'd0 || gio_sub !== 1'b0 || out_data !== 35'd0) begin
      errors++;
      $display("[TB] FAIL reset_data: got idx=%0d sub=%b data=%0d, need 0 0 0",
               bit_idx, gio_sub, out_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_unsigned();
    logic [34:0] d; int lat, sb, un, pb; bit to;
    for (int i = 0; i < 8; i++) plan[i] = 27'sd1;
    run_op(1'b0, 1'b1, -1, 0, 0, 1'b0, d, lat, sb, to);
    checks++;
    if (d !== 35'd255) begin
      errors++; $display("[TB] FAIL unsigned_data: got %0d, need 255", d);
    end
    checks++;
    if (lat !== 9 || to) begin
      errors++; $display("[TB] FAIL unsigned_latency: got %0d (timeout=%b), need 9", lat, to);
    end
    checks++;
    if (sb !== 0) begin
      errors++; $display("[TB] FAIL unsigned_sequence: got %0d bad cycles, need 0", sb);
    end
    finish_op(0, 1'b0, 1'b1, un, pb);
    checks++;
    if (pb !== 0) begin
      errors++; $display("[TB] FAIL unsigned_handoff: got %0d bad, need 0", pb);
    end
  endtask

  task automatic test_signed();
    logic [34:0] d; int lat, sb, un, pb; bit to;
    for (int i = 0; i < 8; i++) plan[i] = 27'sd1;
    run_op(1'b1, 1'b0, -1, 0, 0, 1'b0, d, lat, sb, to);
    checks++;
    if (d !== {35{1'b1}} || sb !== 0 || to) begin
      errors++; $display("[TB] FAIL signed_ones: got %h seq=%0d, need %h seq=0", d, sb, {35{1'b1}});
    end
    finish_op(0, 1'b0, 1'b0, un, pb);
    for (int i = 0; i < 7; i++) plan[i] = 27'sd0;
    plan[7] = -27'sd3;
    run_op(1'b1, 1'b0, -1, 0, 0, 1'b0, d, lat, sb, to);
    checks++;
    if (d !== 35'd384) begin
      errors++; $display("[TB] FAIL signed_msb: got %0d, need 384", d);
    end
    finish_op(0, 1'b0, 1'b0, un, pb);
  endtask

  task automatic test_stall();
    logic [34:0] d, exp; int lat, sb, un, pb; bit to;
    for (int i = 0; i < 8; i++) plan[i] = 27'($urandom);
    exp = model_result(1'b0);
    run_op(1'b0, 1'b0, 5, 3, 0, 1'b0, d, lat, sb, to);
    checks++;
    if (d !== exp) begin
      errors++; $display("[TB] FAIL stall_data: got %h, need %h", d, exp);
    end
    checks++;
    if (lat !== 12 || to) begin
      errors++; $display("[TB] FAIL stall_latency: got %0d (timeout=%b), need 12", lat, to);
    end
    checks++;
    if (sb !== 0) begin
      errors++; $display("[TB] FAIL stall_hold_idx: got %0d bad cycles, need 0", sb);
    end
    finish_op(0, 1'b0, 1'b0, un, pb);
  endtask

  task automatic test_backpressure();
    logic [34:0] d, exp; int lat, sb, un, pb; bit to;
    for (int i = 0; i < 8; i++) plan[i] = 27'($urandom);
    exp = model_result(1'b1);
    run_op(1'b1, 1'b1, -1, 0, 0, 1'b1, d, lat, sb, to);
    checks++;
    if (d !== exp || sb !== 0 || to) begin
      errors++; $display("[TB] FAIL bp_data: got %h seq=%0d, need %h seq=0", d, sb, exp);
    end
    finish_op(5, 1'b1, 1'b1, un, pb);
    checks++;
    if (un !== 0) begin
      errors++; $display("[TB] FAIL bp_stable: got %0d unstable cycles, need 0", un);
    end
    checks++;
    if (pb !== 0) begin
      errors++; $display("[TB] FAIL bp_ignored_start: got %0d bad after handoff, need 0", pb);
    end
  endtask

  task automatic test_reset_mid();
    logic [34:0] d; int lat, sb, un, pb; bit to;
    for (int i = 0; i < 8; i++) plan[i] = 27'($urandom);
    start = 1'b1; cfg_signed = 1'b1; cfg_sub = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int c = 7; c > 3; c--) begin
      psum_valid = 1'b1; psum_in = plan[c];
      @(posedge clk);
      @(negedge clk);
    end
    psum_valid = 1'b0;
    checks++;
    if (bit_idx !== 3'd3 || gio_sub !== 1'b1) begin
      errors++; $display("[TB] FAIL mid_pre_reset: got idx=%0d sub=%b, need 3 1", bit_idx, gio_sub);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (start_ready !== 1'b1 || busy !== 1'b0 || psum_ready !== 1'b0 || out_valid !== 1'b0 ||
        bit_idx !== 3'd0 || gio_sub !== 1'b0 || out_data !== 35'd0) begin
      errors++;
      $display("[TB] FAIL mid_reset: got sr=%b busy=%b pr=%b ov=%b idx=%0d sub=%b data=%0d, need reset values",
               start_ready, busy, psum_ready, out_valid, bit_idx, gio_sub, out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) plan[i] = 27'sd2;
    run_op(1'b0, 1'b0, -1, 0, 0, 1'b0, d, lat, sb, to);
    checks++;
    if (d !== 35'd510 || lat !== 9 || to) begin
      errors++; $display("[TB] FAIL mid_rerun: got %0d lat=%0d, need 510 lat=9", d, lat);
    end
    finish_op(0, 1'b0, 1'b0, un, pb);
  endtask

  task automatic test_width();
    logic [34:0] d; int lat, sb, un, pb; bit to;
    for (int i = 0; i < 8; i++) plan[i] = 27'sh3FFFFFF;
    run_op(1'b0, 1'b0, -1, 0, 0, 1'b0, d, lat, sb, to);
    checks++;
    if (d !== 35'd17112760065) begin
      errors++; $display("[TB] FAIL width_boundary: got %0d, need 17112760065", d);
    end
    finish_op(0, 1'b0, 1'b0, un, pb);
  endtask

  task automatic test_back_to_back();
    logic [34:0] d, exp; int lat, sb, un, pb; bit to, sgn, sub;
    for (int n = 0; n < 10; n++) begin
      for (int i = 0; i < 8; i++) plan[i] = 27'($urandom);
      sgn = 1'($urandom);
      sub = 1'($urandom);
      exp = model_result(sgn);
      run_op(sgn, sub, -1, 0, (n < 5) ? 0 : 30, 1'b0, d, lat, sb, to);
      checks++;
      if (d !== exp || sb !== 0 || to) begin
        errors++;
        $display("[TB] FAIL b2b_op%0d: got %h seq=%0d timeout=%b, need %h seq=0", n, d, sb, to, exp);
      end
      finish_op(0, 1'b0, sub, un, pb);
      checks++;
      if (pb !== 0) begin
        errors++; $display("[TB] FAIL b2b_handoff%0d: got %0d bad, need 0", n, pb);
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_stall();
    test_backpressure();
    test_reset_mid();
    test_width();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
